// File: rtl/branch_resolve_unit_if.sv
// Bundles the uop issue handshake and the registered resolve/redirect outputs of branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int IMM_WIDTH  = 21
);
  logic                  uop_valid_in;
  logic                  uop_is_branch;
  logic                  uop_ready;
  logic [2:0]            ctrl_branch;
  logic [DATA_WIDTH-1:0] src1;
  logic [DATA_WIDTH-1:0] src2;
  logic [IMM_WIDTH-1:0]  immediate;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pred_taken;
  logic [ADDR_WIDTH-1:0] pred_target;
  logic                  system_stall;
  logic                  res_valid;
  logic                  res_taken;
  logic [ADDR_WIDTH-1:0] res_target;
  logic [ADDR_WIDTH-1:0] res_link;
  logic                  res_misaligned;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  flush;
  logic [31:0]           branch_count;
  logic [31:0]           mispredict_count;

  modport master (
    output uop_valid_in, uop_is_branch, ctrl_branch, src1, src2, immediate, pc,
           pred_taken, pred_target, system_stall,
    input  uop_ready, res_valid, res_taken, res_target, res_link, res_misaligned,
           redirect_valid, redirect_pc, flush, branch_count, mispredict_count
  );

  modport slave (
    input  uop_valid_in, uop_is_branch, ctrl_branch, src1, src2, immediate, pc,
           pred_taken, pred_target, system_stall,
    output uop_ready, res_valid, res_taken, res_target, res_link, res_misaligned,
           redirect_valid, redirect_pc, flush, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves control-transfer uops, checks them against the fetch prediction and drives redirect/flush.
// Optional performance counters are enabled with the BRU_PERF_CNT_EN macro.
module branch_resolve_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int IMM_WIDTH    = 21,
  parameter int INSTR_BYTES  = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  branch_resolve_unit_if.slave bus
);
  typedef enum logic {IDLE, FLUSH} state_t;

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] imm_ext;
  logic [ADDR_WIDTH-1:0] seq;
  logic [ADDR_WIDTH-1:0] target;
  logic                  taken;
  logic                  is_link;
  logic                  misaligned;
  logic                  mispredict;
  logic                  accept;

  always_comb begin
    imm_ext    = ADDR_WIDTH'($signed(bus.immediate));
    seq        = bus.pc + ADDR_WIDTH'(INSTR_BYTES);
    target     = bus.pc + imm_ext;
    taken      = 1'b0;
    is_link    = 1'b0;
    case (bus.ctrl_branch)
      3'b000: taken = (bus.src1 == bus.src2);
      3'b001: taken = (bus.src1 != bus.src2);
      3'b010: begin
        taken   = 1'b1;
        is_link = 1'b1;
      end
      3'b011: begin
        taken   = 1'b1;
        is_link = 1'b1;
        target  = (ADDR_WIDTH'(bus.src1) + imm_ext) & ~ADDR_WIDTH'(1);
      end
      3'b100: taken = ($signed(bus.src1) <  $signed(bus.src2));
      3'b101: taken = ($signed(bus.src1) >= $signed(bus.src2));
      3'b110: taken = (bus.src1 <  bus.src2);
      default: taken = (bus.src1 >= bus.src2);
    endcase
    misaligned = taken & (|(target & ALIGN_MASK));
    // A wrong target only matters when the branch is actually taken.
    mispredict = (taken != bus.pred_taken) | (taken & (target != bus.pred_target));
    accept     = bus.uop_valid_in & bus.uop_is_branch & bus.uop_ready & ~bus.system_stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      bus.uop_ready      <= 1'b1;
      bus.res_valid      <= 1'b0;
      bus.res_taken      <= 1'b0;
      bus.res_target     <= '0;
      bus.res_link       <= '0;
      bus.res_misaligned <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.flush          <= 1'b0;
    end else begin
      bus.res_valid      <= 1'b0;
      bus.redirect_valid <= 1'b0;
      if (!bus.system_stall) begin
        if (accept) begin
          bus.res_valid      <= 1'b1;
          bus.res_taken      <= taken;
          bus.res_target     <= taken ? target : seq;
          bus.res_link       <= is_link ? seq : '0;
          bus.res_misaligned <= misaligned;
          // Misaligned targets trap instead of redirecting fetch.
          if (mispredict && !misaligned) begin
            bus.redirect_valid <= 1'b1;
            bus.redirect_pc    <= taken ? target : seq;
            bus.flush          <= 1'b1;
            bus.uop_ready      <= 1'b0;
            state              <= FLUSH;
            cnt                <= CNT_W'(FLUSH_CYCLES - 1);
          end
        end else if (state == FLUSH) begin
          if (cnt == '0) begin
            state         <= IDLE;
            bus.flush     <= 1'b0;
            bus.uop_ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.branch_count     <= '0;
      bus.mispredict_count <= '0;
    end else if (accept) begin
      if (bus.branch_count != 32'hFFFF_FFFF)
        bus.branch_count <= bus.branch_count + 32'd1;
      if (mispredict && !misaligned && bus.mispredict_count != 32'hFFFF_FFFF)
        bus.mispredict_count <= bus.mispredict_count + 32'd1;
    end
  end
`else
  assign bus.branch_count     = '0;
  assign bus.mispredict_count = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default parameters, FLUSH_CYCLES=2).
module tb_branch_resolve_unit;
  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  branch_resolve_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .IMM_WIDTH(21)) bus ();

  branch_resolve_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .IMM_WIDTH(21), .INSTR_BYTES(4), .FLUSH_CYCLES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic is_br, input logic [2:0] ctrl,
                                input logic [31:0] s1, input logic [31:0] s2,
                                input logic [20:0] imm, input logic [31:0] pc,
                                input logic pt, input logic [31:0] ptgt);
    bus.uop_valid_in  = valid;
    bus.uop_is_branch = is_br;
    bus.ctrl_branch   = ctrl;
    bus.src1          = s1;
    bus.src2          = s2;
    bus.immediate     = imm;
    bus.pc            = pc;
    bus.pred_taken    = pt;
    bus.pred_target   = ptgt;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle_uop();
    apply_stimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 21'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    bus.system_stall = 1'b0;
    idle_uop();
    step();
    step();
    check_output("rst_ready", bus.uop_ready, 1);
    check_output("rst_res_valid", bus.res_valid, 0);
    check_output("rst_flush", bus.flush, 0);
    check_output("rst_redirect", bus.redirect_valid, 0);
    check_output("rst_target", bus.res_target, 0);
    check_output("rst_bcount", bus.branch_count, 0);
    reset = 1'b0;

    // BEQ correctly predicted taken
    apply_stimulus(1, 1, 3'b000, 32'd5, 32'd5, 21'h20, 32'h100, 1, 32'h120);
    step();
    check_output("beq_valid", bus.res_valid, 1);
    check_output("beq_taken", bus.res_taken, 1);
    check_output("beq_target", bus.res_target, 32'h120);
    check_output("beq_link", bus.res_link, 0);
    check_output("beq_redirect", bus.redirect_valid, 0);
    check_output("beq_flush", bus.flush, 0);
    idle_uop();
    step();
    check_output("hold_valid", bus.res_valid, 0);
    check_output("hold_target", bus.res_target, 32'h120);

    // BLT signed vs BLTU unsigned, back to back
    apply_stimulus(1, 1, 3'b100, 32'hFFFF_FFFF, 32'd1, 21'h40, 32'h200, 1, 32'h240);
    step();
    check_output("blt_taken", bus.res_taken, 1);
    check_output("blt_target", bus.res_target, 32'h240);
    check_output("blt_redirect", bus.redirect_valid, 0);
    apply_stimulus(1, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 21'h40, 32'h200, 0, 32'h0);
    step();
    check_output("bltu_valid", bus.res_valid, 1);
    check_output("bltu_taken", bus.res_taken, 0);
    check_output("bltu_target", bus.res_target, 32'h204);
    check_output("bltu_redirect", bus.redirect_valid, 0);

    // BNE mispredicted not-taken: redirect pulse then two flush cycles
    apply_stimulus(1, 1, 3'b001, 32'd1, 32'd2, 21'h80, 32'h300, 0, 32'h0);
    step();
    check_output("bne_valid", bus.res_valid, 1);
    check_output("bne_redirect", bus.redirect_valid, 1);
    check_output("bne_redirect_pc", bus.redirect_pc, 32'h380);
    check_output("bne_flush1", bus.flush, 1);
    check_output("bne_ready1", bus.uop_ready, 0);
    apply_stimulus(1, 1, 3'b000, 32'd3, 32'd3, 21'h8, 32'h600, 1, 32'h608);
    step();
    check_output("bne_redirect_drop", bus.redirect_valid, 0);
    check_output("bne_flush2", bus.flush, 1);
    check_output("bne_ready2", bus.uop_ready, 0);
    check_output("flush_ignored_valid", bus.res_valid, 0);
    check_output("flush_ignored_target", bus.res_target, 32'h380);
    idle_uop();
    step();
    check_output("bne_flush_end", bus.flush, 0);
    check_output("bne_ready_back", bus.uop_ready, 1);

    // JALR aligned, then misaligned with a wrong prediction
    apply_stimulus(1, 1, 3'b011, 32'h2001, 32'h0, 21'h10, 32'h40, 1, 32'h2010);
    step();
    check_output("jalr_target", bus.res_target, 32'h2010);
    check_output("jalr_link", bus.res_link, 32'h44);
    check_output("jalr_misaligned", bus.res_misaligned, 0);
    check_output("jalr_redirect", bus.redirect_valid, 0);
    apply_stimulus(1, 1, 3'b011, 32'h2001, 32'h0, 21'h12, 32'h40, 0, 32'h0);
    step();
    check_output("jalr_mis_target", bus.res_target, 32'h2012);
    check_output("jalr_mis_flag", bus.res_misaligned, 1);
    check_output("jalr_mis_redirect", bus.redirect_valid, 0);
    check_output("jalr_mis_flush", bus.flush, 0);

    // JAL backward with wrong predicted target
    apply_stimulus(1, 1, 3'b010, 32'h0, 32'h0, 21'h1F_FF00, 32'h1000, 1, 32'h0);
    step();
    check_output("jal_target", bus.res_target, 32'hF00);
    check_output("jal_link", bus.res_link, 32'h1004);
    check_output("jal_redirect", bus.redirect_valid, 1);
    check_output("jal_redirect_pc", bus.redirect_pc, 32'hF00);

    // Stall during flush freezes the countdown
    idle_uop();
    bus.system_stall = 1'b1;
    step();
    check_output("stall_redirect", bus.redirect_valid, 0);
    check_output("stall_flush1", bus.flush, 1);
    step();
    check_output("stall_flush2", bus.flush, 1);
    bus.system_stall = 1'b0;
    step();
    check_output("unstall_flush", bus.flush, 1);
    check_output("unstall_ready", bus.uop_ready, 0);
    step();
    check_output("stall_flush_end", bus.flush, 0);
    check_output("stall_ready_back", bus.uop_ready, 1);

    // Non-branch uop is ignored
    apply_stimulus(1, 0, 3'b000, 32'd1, 32'd1, 21'h40, 32'h900, 1, 32'h940);
    step();
    check_output("nonbr_valid", bus.res_valid, 0);
    check_output("nonbr_target", bus.res_target, 32'hF00);

    // Stalled branch waits, then BGE/BGEU resolve
    apply_stimulus(1, 1, 3'b101, 32'd1, 32'hFFFF_FFFF, 21'h10, 32'h700, 1, 32'h710);
    bus.system_stall = 1'b1;
    step();
    check_output("stalled_valid", bus.res_valid, 0);
    check_output("stalled_target", bus.res_target, 32'hF00);
    bus.system_stall = 1'b0;
    step();
    check_output("bge_valid", bus.res_valid, 1);
    check_output("bge_taken", bus.res_taken, 1);
    check_output("bge_target", bus.res_target, 32'h710);
    apply_stimulus(1, 1, 3'b111, 32'd1, 32'hFFFF_FFFF, 21'h10, 32'h720, 0, 32'h0);
    step();
    check_output("bgeu_taken", bus.res_taken, 0);
    check_output("bgeu_target", bus.res_target, 32'h724);
    check_output("bgeu_redirect", bus.redirect_valid, 0);

    // Mispredicted BEQ, then reset in the middle of its flush
    apply_stimulus(1, 1, 3'b000, 32'd9, 32'd9, 21'h20, 32'h800, 0, 32'h0);
    step();
    check_output("beq_mp_redirect_pc", bus.redirect_pc, 32'h820);
    check_output("beq_mp_flush", bus.flush, 1);
`ifdef BRU_PERF_CNT_EN
    check_output("branch_count", bus.branch_count, 10);
    check_output("mispredict_count", bus.mispredict_count, 3);
`else
    check_output("branch_count", bus.branch_count, 0);
    check_output("mispredict_count", bus.mispredict_count, 0);
`endif
    idle_uop();
    reset = 1'b1;
    step();
    check_output("midrst_flush", bus.flush, 0);
    check_output("midrst_ready", bus.uop_ready, 1);
    check_output("midrst_redirect", bus.redirect_valid, 0);
    check_output("midrst_bcount", bus.branch_count, 0);
    check_output("midrst_mcount", bus.mispredict_count, 0);
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
